// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Data-hazard unit for a 5-stage MIPS-style pipeline, sitting beside ID.
// It follows every in-flight register writer in a shift-register scoreboard.
// Slot 0 is EX, slot 1 is EX/MEM, slot 2 is MEM/WB, and so on. From that
// scoreboard it produces registered forwarding selects for the instruction
// that is about to enter EX. It stalls only in two cases:
//   * load-use: the youngest writer of a source is a load still in EX;
//   * multi-cycle occupancy: a mul holds EX for MUL_LAT cycles.
//
// Parameters
//   REGW     register-index width (register 0 is hard-wired zero)
//   DEPTH    tracked slots after ID, 3..8
//   MUL_LAT  EX cycles occupied by a multi-cycle op, 1..16
//   FSEL_W   forward-select width, clog2(DEPTH)
//   CNT_W    stall performance counter width
//
// Ports
//   Clk, Reset_n         clock, asynchronous active-low reset
//   id_valid             ID holds a real instruction
//   id_rs/_used          source A index and use flag
//   id_rt/_used          source B index and use flag
//   id_rd, id_wr         destination index and write flag
//   id_load, id_multi    instruction is a load / a multi-cycle op
//   flush                squash the ID instruction
//   pc_write, ifid_write front-end enables (low while stalled)
//   ctrl_mux             0 = inject a bubble into ID/EX
//   ex_hold              freeze ID/EX and EX; EX/MEM receives a bubble
//   fwd_rs, fwd_rt       EX operand sources: 0 = register file, k = slot k
//   load_use             the current stall is a load-use stall
//   stall_count          saturating count of stall cycles
//
// Stall handshake: stall is a combinational "not ready" returned to ID in the
// same cycle the hazard is seen. The ID instruction is accepted (advances into
// slot 0) only on a clock edge where id_valid=1, stall=0 and flush=0. While
// stall=1 the front end must hold the ID instruction stable.
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
    parameter int REGW    = 5,
    parameter int DEPTH   = 3,
    parameter int MUL_LAT = 2,
    parameter int FSEL_W  = $clog2(DEPTH),
    parameter int CNT_W   = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              id_valid,
    input  logic [REGW-1:0]   id_rs,
    input  logic              id_rs_used,
    input  logic [REGW-1:0]   id_rt,
    input  logic              id_rt_used,
    input  logic [REGW-1:0]   id_rd,
    input  logic              id_wr,
    input  logic              id_load,
    input  logic              id_multi,
    input  logic              flush,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ctrl_mux,
    output logic              ex_hold,
    output logic [FSEL_W-1:0] fwd_rs,
    output logic [FSEL_W-1:0] fwd_rt,
    output logic              load_use,
    output logic [CNT_W-1:0]  stall_count
);

    // The remaining-occupancy counter only has to hold MUL_LAT-1 (at most 15).
    localparam int                MCNT_W    = 5;
    localparam logic [MCNT_W-1:0] MCNT_INIT = MCNT_W'(MUL_LAT - 1);
    // A match in the oldest slot retires this cycle, so it is never forwarded.
    localparam logic [FSEL_W-1:0] LAST_SLOT = FSEL_W'(DEPTH - 1);

    // Scoreboard slots. Only the EX slot needs its load flag: a load that has
    // reached slot 1 or older has its data, so it forwards without stalling.
    logic [DEPTH-1:0] slot_v;
    logic [REGW-1:0]  slot_rd [DEPTH];
    logic             slot0_ld;

    logic [MCNT_W-1:0] mcnt;

    logic              rs_hit;
    logic              rt_hit;
    logic [FSEL_W-1:0] rs_j;
    logic [FSEL_W-1:0] rt_j;
    logic [FSEL_W-1:0] rs_sel;
    logic [FSEL_W-1:0] rt_sel;
    logic              stall;
    logic              advance;

    // Youngest-writer search. The loop runs from oldest to youngest, so the
    // last hit it records is the smallest matching index.
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        rs_j   = '0;
        rt_j   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (id_rs_used && (id_rs != '0) && slot_v[i] && (slot_rd[i] == id_rs)) begin
                rs_hit = 1'b1;
                rs_j   = FSEL_W'(i);
            end
            if (id_rt_used && (id_rt != '0) && slot_v[i] && (slot_rd[i] == id_rt)) begin
                rt_hit = 1'b1;
                rt_j   = FSEL_W'(i);
            end
        end
    end

    // Next-cycle forward selects. The writer found in slot j will be in slot
    // j+1 once the consumer reaches EX. A writer in the last slot is being
    // written back now, and the register file reads after it writes.
    always_comb begin
        rs_sel = '0;
        rt_sel = '0;
        if (rs_hit && (rs_j != LAST_SLOT)) begin
            rs_sel = rs_j + 1'b1;
        end
        if (rt_hit && (rt_j != LAST_SLOT)) begin
            rt_sel = rt_j + 1'b1;
        end
    end

    always_comb begin
        load_use = id_valid && !flush && slot0_ld &&
                   ((rs_hit && (rs_j == '0)) || (rt_hit && (rt_j == '0)));
        ex_hold    = (mcnt != '0);
        stall      = ex_hold || load_use;
        pc_write   = !stall;
        ifid_write = !stall;
        ctrl_mux   = !stall;
        advance    = id_valid && !stall && !flush;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            slot_v      <= '0;
            slot0_ld    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_rd[i] <= '0;
            end
            mcnt        <= '0;
            fwd_rs      <= '0;
            fwd_rt      <= '0;
            stall_count <= '0;
        end else begin
            if (stall && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + 1'b1;
            end

            // Destination indices shift unconditionally. A slot whose valid
            // bit is clear is never matched, so its index is don't-care.
            for (int i = 1; i < DEPTH; i++) begin
                slot_rd[i] <= slot_rd[i-1];
            end

            if (!ex_hold) begin
                // Normal advance. A stalled or squashed ID enters as a bubble.
                slot_v[0]  <= advance && id_wr && (id_rd != '0);
                slot_rd[0] <= id_rd;
                slot0_ld   <= id_load;
                for (int i = 1; i < DEPTH; i++) begin
                    slot_v[i] <= slot_v[i-1];
                end
                if (advance && id_multi) begin
                    mcnt <= MCNT_INIT;
                end
                fwd_rs <= advance ? rs_sel : '0;
                fwd_rt <= advance ? rt_sel : '0;
            end else begin
                // EX is occupied: its slot stays put, EX/MEM takes a bubble,
                // and the older slots keep draining. The forward selects stay
                // with the instruction frozen in EX.
                slot_v[1] <= 1'b0;
                for (int i = 2; i < DEPTH; i++) begin
                    slot_v[i] <= slot_v[i-1];
                end
                mcnt <= mcnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_unit
//
// Directed bench for hazard_forward_unit (DEPTH=3, MUL_LAT=3, CNT_W=4).
// Each cycle the driver sets the ID-stage inputs and pushes the expected
// outputs for that cycle into exp_q. The monitor pops and compares on every
// falling edge.
// Expected word: {pc_write, ifid_write, ctrl_mux, ex_hold, load_use,
//                 fwd_rs[1:0], fwd_rt[1:0], stall_count[3:0]}
// -----------------------------------------------------------------------------
module tb_hazard_forward_unit;

    localparam int REGW    = 5;
    localparam int DEPTH   = 3;
    localparam int MUL_LAT = 3;
    localparam int FSEL_W  = 2;
    localparam int CNT_W   = 4;
    localparam int OW      = 13;

    logic              Clk;
    logic              Reset_n;
    logic              id_valid;
    logic [REGW-1:0]   id_rs;
    logic              id_rs_used;
    logic [REGW-1:0]   id_rt;
    logic              id_rt_used;
    logic [REGW-1:0]   id_rd;
    logic              id_wr;
    logic              id_load;
    logic              id_multi;
    logic              flush;
    logic              pc_write;
    logic              ifid_write;
    logic              ctrl_mux;
    logic              ex_hold;
    logic [FSEL_W-1:0] fwd_rs;
    logic [FSEL_W-1:0] fwd_rt;
    logic              load_use;
    logic [CNT_W-1:0]  stall_count;

    logic [OW-1:0] exp_q[$];
    string         name_q[$];
    int            n_vec;
    int            n_bad;

    hazard_forward_unit #(
        .REGW    (REGW),
        .DEPTH   (DEPTH),
        .MUL_LAT (MUL_LAT),
        .FSEL_W  (FSEL_W),
        .CNT_W   (CNT_W)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rs_used  (id_rs_used),
        .id_rt       (id_rt),
        .id_rt_used  (id_rt_used),
        .id_rd       (id_rd),
        .id_wr       (id_wr),
        .id_load     (id_load),
        .id_multi    (id_multi),
        .flush       (flush),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .ctrl_mux    (ctrl_mux),
        .ex_hold     (ex_hold),
        .fwd_rs      (fwd_rs),
        .fwd_rt      (fwd_rt),
        .load_use    (load_use),
        .stall_count (stall_count)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic set_id(input logic v, input logic [4:0] rs, input logic rsu,
                          input logic [4:0] rt, input logic rtu, input logic [4:0] rd,
                          input logic wr, input logic ld, input logic mul, input logic fl);
        id_valid   = v;
        id_rs      = rs;
        id_rs_used = rsu;
        id_rt      = rt;
        id_rt_used = rtu;
        id_rd      = rd;
        id_wr      = wr;
        id_load    = ld;
        id_multi   = mul;
        flush      = fl;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        set_id(1'b1, rs, 1'b1, rt, 1'b1, rd, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lw(input logic [4:0] rd, input logic [4:0] base);
        set_id(1'b1, base, 1'b1, 5'd0, 1'b0, rd, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic mul(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        set_id(1'b1, rs, 1'b1, rt, 1'b1, rd, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    // Push this cycle's expected outputs, then move to just after the next edge.
    task automatic expect_cycle(input string name, input logic ns, input logic hold,
                                input logic lu, input logic [1:0] frs,
                                input logic [1:0] frt, input logic [3:0] cnt);
        exp_q.push_back({ns, ns, ns, hold, lu, frs, frt, cnt});
        name_q.push_back(name);
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        idle();
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    function automatic logic [3:0] sat(input int x);
        return (x > 15) ? 4'd15 : 4'(x);
    endfunction

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [OW-1:0] e;
        logic [OW-1:0] act;
        string         n;
        forever begin
            @(negedge Clk);
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                n   = name_q.pop_front();
                act = {pc_write, ifid_write, ctrl_mux, ex_hold, load_use,
                       fwd_rs, fwd_rt, stall_count};
                n_vec++;
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL %s: got %b expected %b", n, act, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_vec   = 0;
        n_bad   = 0;
        Reset_n = 1'b0;
        idle();
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        expect_cycle("reset_state", 1, 0, 0, 2'd0, 2'd0, 4'd0);

        // Back-to-back ALU dependencies.
        alu(5'd3, 5'd1, 5'd2);  expect_cycle("alu_add3",      1, 0, 0, 2'd0, 2'd0, 4'd0);
        alu(5'd4, 5'd1, 5'd2);  expect_cycle("alu_add4",      1, 0, 0, 2'd0, 2'd0, 4'd0);
        alu(5'd5, 5'd3, 5'd4);  expect_cycle("alu_sub_id",    1, 0, 0, 2'd0, 2'd0, 4'd0);
        alu(5'd7, 5'd5, 5'd3);  expect_cycle("alu_two_wr",    1, 0, 0, 2'd2, 2'd1, 4'd0);
        idle();                 expect_cycle("alu_dist_depth",1, 0, 0, 2'd1, 2'd0, 4'd0);
        idle();                 expect_cycle("alu_bubble",    1, 0, 0, 2'd0, 2'd0, 4'd0);

        // Zero register: a load to $0 never creates a hazard.
        do_reset();
        lw(5'd0, 5'd1);         expect_cycle("zero_lw",       1, 0, 0, 2'd0, 2'd0, 4'd0);
        alu(5'd8, 5'd0, 5'd0);  expect_cycle("zero_read",     1, 0, 0, 2'd0, 2'd0, 4'd0);
        idle();                 expect_cycle("zero_fwd",      1, 0, 0, 2'd0, 2'd0, 4'd0);

        // Load-use: one stall cycle, then forward from MEM/WB.
        do_reset();
        lw(5'd2, 5'd1);         expect_cycle("lu_lw",         1, 0, 0, 2'd0, 2'd0, 4'd0);
        alu(5'd6, 5'd2, 5'd2);  expect_cycle("lu_stall",      0, 0, 1, 2'd0, 2'd0, 4'd0);
        alu(5'd6, 5'd2, 5'd2);  expect_cycle("lu_release",    1, 0, 0, 2'd0, 2'd0, 4'd1);
        idle();                 expect_cycle("lu_fwd",        1, 0, 0, 2'd2, 2'd2, 4'd1);
        idle();                 expect_cycle("lu_after",      1, 0, 0, 2'd0, 2'd0, 4'd1);

        // Multi-cycle op: fwd of the mul itself is held through ex_hold.
        do_reset();
        alu(5'd1, 5'd2, 5'd3);  expect_cycle("mul_pre",       1, 0, 0, 2'd0, 2'd0, 4'd0);
        mul(5'd7, 5'd1, 5'd2);  expect_cycle("mul_issue",     1, 0, 0, 2'd0, 2'd0, 4'd0);
        alu(5'd8, 5'd7, 5'd1);  expect_cycle("mul_hold1",     0, 1, 0, 2'd1, 2'd0, 4'd0);
        alu(5'd8, 5'd7, 5'd1);  expect_cycle("mul_hold2",     0, 1, 0, 2'd1, 2'd0, 4'd1);
        alu(5'd8, 5'd7, 5'd1);  expect_cycle("mul_release",   1, 0, 0, 2'd1, 2'd0, 4'd2);
        idle();                 expect_cycle("mul_fwd",       1, 0, 0, 2'd1, 2'd0, 4'd2);
        idle();                 expect_cycle("mul_after",     1, 0, 0, 2'd0, 2'd0, 4'd2);

        // Youngest writer wins; flush suppresses load-use and the ID entry.
        do_reset();
        alu(5'd9, 5'd1, 5'd2);  expect_cycle("yw_first",      1, 0, 0, 2'd0, 2'd0, 4'd0);
        alu(5'd9, 5'd3, 5'd4);  expect_cycle("yw_second",     1, 0, 0, 2'd0, 2'd0, 4'd0);
        alu(5'd10, 5'd9, 5'd0); expect_cycle("yw_read",       1, 0, 0, 2'd0, 2'd0, 4'd0);
        lw(5'd11, 5'd1);        expect_cycle("yw_fwd",        1, 0, 0, 2'd1, 2'd0, 4'd0);
        set_id(1'b1, 5'd11, 1'b1, 5'd11, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1);
                                expect_cycle("flush_nostall", 1, 0, 0, 2'd0, 2'd0, 4'd0);
        alu(5'd13, 5'd12, 5'd11); expect_cycle("flush_next",  1, 0, 0, 2'd0, 2'd0, 4'd0);
        idle();                 expect_cycle("flush_fwd",     1, 0, 0, 2'd0, 2'd2, 4'd0);

        // Asynchronous reset in the middle of ex_hold (no clock edge between
        // asserting reset and the check).
        do_reset();
        mul(5'd7, 5'd1, 5'd2);  expect_cycle("ar_mul",        1, 0, 0, 2'd0, 2'd0, 4'd0);
        alu(5'd8, 5'd7, 5'd1);  expect_cycle("ar_hold",       0, 1, 0, 2'd0, 2'd0, 4'd0);
        Reset_n = 1'b0;         expect_cycle("ar_async",      1, 0, 0, 2'd0, 2'd0, 4'd0);
        Reset_n = 1'b1;
        idle();                 expect_cycle("ar_after",      1, 0, 0, 2'd0, 2'd0, 4'd0);

        // Saturation: ten back-to-back muls give 20 stall cycles.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            mul(5'd7, 5'd1, 5'd2);
            expect_cycle("sat_issue", 1, 0, 0, 2'd0, 2'd0, sat(2 * k));
            for (int h = 0; h < 2; h++) begin
                if (k < 9) mul(5'd7, 5'd1, 5'd2);
                else       idle();
                expect_cycle("sat_hold", 0, 1, 0, 2'd0, 2'd0, sat(2 * k + h));
            end
        end
        idle();                 expect_cycle("sat_final",     1, 0, 0, 2'd0, 2'd0, 4'd15);

        @(negedge Clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised successor to the stall-only data hazard detector in the 5-stage MIPS pipeline.
- Tracks in-flight register writers in a shift-register scoreboard and issues registered forwarding selects for the instruction entering EX.
- Stalls only for load-use hazards and for multi-cycle (mul) occupancy of EX.
- Sits beside the ID stage; drives PC write, IF/ID write, the control bubble mux, the ID/EX hold and the EX operand muxes.

Parameters:
- REGW, 5, register-index width; the register file has 2^REGW entries and register 0 is hard-wired zero.
- DEPTH, 3, tracked slots after ID (slot 0 = EX, 1 = EX/MEM, 2 = MEM/WB, ...); legal range 3 to 8.
- MUL_LAT, 2, EX cycles occupied by a multi-cycle op; legal range 1 to 16.
- FSEL_W, clog2(DEPTH), width of a forward select.
- CNT_W, 16, stall performance counter width.

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous active-low reset.
- id_valid  in  1  the ID stage holds a real instruction.
- id_rs  in  REGW  source register A.
- id_rs_used  in  1  the instruction reads rs.
- id_rt  in  REGW  source register B.
- id_rt_used  in  1  the instruction reads rt.
- id_rd  in  REGW  destination register.
- id_wr  in  1  the instruction writes id_rd.
- id_load  in  1  the instruction is a load (lw/lh/lb).
- id_multi  in  1  the instruction is multi-cycle (mul).
- flush  in  1  squash the ID instruction (taken branch or jump).
- pc_write  out  1  PC enable.
- ifid_write  out  1  IF/ID enable.
- ctrl_mux  out  1  0 means insert a bubble into ID/EX.
- ex_hold  out  1  freeze ID/EX and EX; EX/MEM receives a bubble.
- fwd_rs  out  FSEL_W  EX operand-A source: 0 = register file, k = slot k.
- fwd_rt  out  FSEL_W  EX operand-B source, same encoding as fwd_rs.
- load_use  out  1  status: the current stall is caused by a load-use hazard.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Slot state: each slot S[i] holds {v, rd, ld}. On reset all v=0, mcnt=0, fwd_rs=fwd_rt=0, stall_count=0.
- Outputs after reset: stall=0, so pc_write=ifid_write=ctrl_mux=1, and ex_hold=0.
- Source match: source r matches slot i when the source is used, r!=0, S[i].v=1 and S[i].rd==r. j is the smallest matching index (the youngest writer wins).
- load_use: asserted when j==0 and S[0].ld, for either source, and id_valid=1 and flush=0.
- Combinational outputs: ex_hold = (mcnt!=0); stall = ex_hold | load_use; pc_write = ifid_write = ctrl_mux = !stall.
- advance = id_valid & !stall & !flush.
- Clock edge, ex_hold=0:
  - S[0] <= {advance & id_wr & (id_rd!=0), id_rd, id_load}.
  - S[i] <= S[i-1] for i>=1.
  - If advance & id_multi, then mcnt <= MUL_LAT-1.
- Clock edge, ex_hold=1:
  - S[0] holds and S[1] <= invalid (bubble).
  - S[i] <= S[i-1] for i>=2.
  - mcnt <= mcnt-1.
- Forward selects are registered. On an edge with ex_hold=0:
  - If advance, fwd_x <= j+1 when a match exists and j+1 <= DEPTH-1; otherwise 0.
  - A match in S[DEPTH-1] retires, so its value comes from the register file; the register file is write-before-read.
  - If not advance, fwd_x <= 0 (bubble).
- While ex_hold=1, fwd_rs and fwd_rt hold their values.
- A load in S[1] or older forwards without a stall, because its data is valid from slot 2 onward.
- Latency: a hazard decision is combinational in the same cycle; the forward select is valid in the first cycle the consumer sits in EX.
- flush with stall: flush suppresses load_use and prevents the ID instruction from entering the slots. Any stall from ex_hold still applies.
- stall_count increments on every cycle with stall=1 and saturates at all-ones.
- Reset mid-operation clears all slots, mcnt and the counter immediately, independent of Clk.

Test Plan:
- Back-to-back ALU dependency: add $3 then sub $5,$3,$4 → no stall; fwd_rs=1 in sub's EX cycle. Add $4 as a second intervening writer → fwd_rt=1 and fwd_rs=2.
- Load-use: lw $2 then add $6,$2,$2 → exactly one cycle with pc_write=ifid_write=ctrl_mux=0 and load_use=1; then fwd_rs=fwd_rt=2 and stall_count=1.
- Multi-cycle, MUL_LAT=3: mul $7 then add $8,$7,$1 → ex_hold=1 for 2 cycles, S[1] gets bubbles, then fwd_rs=1 and stall_count=2.
- Zero register and dependency distance:
  - Writer to $0 followed by a reader of $0 → no stall, fwd=0.
  - Reader at distance DEPTH from its writer → fwd=0.
- Youngest wins plus flush: two writers to $9 in S[0] and S[1] → fwd_rs=1. A load-use with flush=1 → no stall, S[0] invalid next cycle.
- Reset and saturation:
  - Reset_n low mid-ex_hold → outputs return to reset values asynchronously.
  - With CNT_W=4 and 20 stall cycles → stall_count=15.
